// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared timing constants and types for the VGA sync controller.
//  - *_DEF constants : default 640x480@60 geometry (porches and sync widths)
//  - H_TOTAL/V_TOTAL : default full line / frame lengths (800 / 525)
//  - coord_t         : 10-bit pixel / line coordinate
//  - phase_e         : timing phase of one axis (active, front porch, sync, back porch)
//  - phase_of()      : phase implied by a count, used to resynchronise the FSMs
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int H_TOTAL       = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;
  localparam int V_TOTAL       = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  // Phase a count belongs to, given the first count of each non-active region.
  function automatic phase_e phase_of(input coord_t c,
                                      input coord_t front_start,
                                      input coord_t sync_start,
                                      input coord_t back_start);
    phase_e p;
    if (c < front_start)      p = PH_ACTIVE;
    else if (c < sync_start)  p = PH_FRONT;
    else if (c < back_start)  p = PH_SYNC;
    else                      p = PH_BACK;
    return p;
  endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// ---------------------------------------------------------------------------
// vga_axis_timer
// One timing axis (horizontal or vertical): an enabled wrap counter running
// 0..TOTAL-1 plus a registered phase FSM that tracks the counter.
// Ports:
//  clk    in   system clock
//  reset  in   synchronous active-low reset
//  en     in   advance enable (one count per clk where en==1)
//  count  out  current count, never exceeds TOTAL-1
//  phase  out  current phase, always consistent with count
//  wrap   out  1-clk pulse on the edge where count wrapped TOTAL-1 -> 0
// ---------------------------------------------------------------------------
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE = H_VISIBLE_DEF,
  parameter int FP      = H_FP_DEF,
  parameter int SYNC    = H_SYNC_DEF,
  parameter int BP      = H_BP_DEF
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  output coord_t count,
  output phase_e phase,
  output logic   wrap
);

  localparam int     TOTAL       = VISIBLE + FP + SYNC + BP;
  localparam coord_t LAST        = coord_t'(TOTAL - 1);
  localparam coord_t FRONT_START = coord_t'(VISIBLE);
  localparam coord_t SYNC_START  = coord_t'(VISIBLE + FP);
  localparam coord_t BACK_START  = coord_t'(VISIBLE + FP + SYNC);

  logic   at_last;
  coord_t count_next;
  phase_e phase_next;

  // ">=" rather than "==" so a corrupted count above LAST still wraps to 0
  // instead of running on towards 1023.
  assign at_last = (count >= LAST);

  always_comb begin
    count_next = at_last ? '0 : count + coord_t'(1);
    phase_next = phase;
    case (phase)
      PH_ACTIVE: if (count_next == FRONT_START) phase_next = PH_FRONT;
      PH_FRONT:  if (count_next == SYNC_START)  phase_next = PH_SYNC;
      PH_SYNC:   if (count_next == BACK_START)  phase_next = PH_BACK;
      PH_BACK:   if (count_next == '0)          phase_next = PH_ACTIVE;
      default:   phase_next = phase_of(count_next, FRONT_START, SYNC_START, BACK_START);
    endcase
    // If the state ever disagrees with the counter, fall back to the phase
    // the counter implies so the two can never stay out of step.
    if (phase != phase_of(count, FRONT_START, SYNC_START, BACK_START)) begin
      phase_next = phase_of(count_next, FRONT_START, SYNC_START, BACK_START);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
      phase <= PH_ACTIVE;
      wrap  <= 1'b0;
    end else if (en) begin
      count <= count_next;
      phase <= phase_next;
      wrap  <= at_last;
    end else begin
      wrap  <= 1'b0;
    end
  end

endmodule

// File: rtl/vga_sync_ctrl.sv
// ---------------------------------------------------------------------------
// vga_sync_ctrl
// Generates VGA timing from a pixel-enable tick on the system clock.
// Ports:
//  clk          in   system clock (100 MHz)
//  reset        in   synchronous active-low reset
//  pclk         in   pixel-enable tick; timing advances only on clks where it is 1
//  h_sync       out  horizontal sync, equals SYNC_POL while asserted
//  v_sync       out  vertical sync, equals SYNC_POL while asserted
//  de           out  display enable (both axes in their visible region)
//  x_pixel      out  horizontal count 0..H_TOTAL-1
//  y_pixel      out  vertical count 0..V_TOTAL-1
//  line_start   out  1-clk pulse when x wraps to 0
//  frame_start  out  1-clk pulse when (x,y) wraps to (0,0)
// ---------------------------------------------------------------------------
module vga_sync_ctrl
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE = H_VISIBLE_DEF,
  parameter int   H_FP      = H_FP_DEF,
  parameter int   H_SYNC    = H_SYNC_DEF,
  parameter int   H_BP      = H_BP_DEF,
  parameter int   V_VISIBLE = V_VISIBLE_DEF,
  parameter int   V_FP      = V_FP_DEF,
  parameter int   V_SYNC    = V_SYNC_DEF,
  parameter int   V_BP      = V_BP_DEF,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pclk,
  output logic       h_sync,
  output logic       v_sync,
  output logic       de,
  output logic [9:0] x_pixel,
  output logic [9:0] y_pixel,
  output logic       line_start,
  output logic       frame_start
);

  localparam int LINE_LEN = H_VISIBLE + H_FP + H_SYNC + H_BP;

  coord_t h_count;
  coord_t v_count;
  phase_e h_phase;
  phase_e v_phase;
  logic   h_wrap;
  logic   v_wrap;
  logic   h_last;
  logic   v_en;

  // The vertical axis steps on the same edge the horizontal axis wraps, so
  // its enable uses the current terminal count rather than the (one clk
  // late) registered wrap pulse.
  assign h_last = (h_count >= coord_t'(LINE_LEN - 1));
  assign v_en   = pclk & h_last;

  vga_axis_timer #(
    .VISIBLE (H_VISIBLE),
    .FP      (H_FP),
    .SYNC    (H_SYNC),
    .BP      (H_BP)
  ) u_h_timer (
    .clk   (clk),
    .reset (reset),
    .en    (pclk),
    .count (h_count),
    .phase (h_phase),
    .wrap  (h_wrap)
  );

  vga_axis_timer #(
    .VISIBLE (V_VISIBLE),
    .FP      (V_FP),
    .SYNC    (V_SYNC),
    .BP      (V_BP)
  ) u_v_timer (
    .clk   (clk),
    .reset (reset),
    .en    (v_en),
    .count (v_count),
    .phase (v_phase),
    .wrap  (v_wrap)
  );

  // All outputs decode registered state only, so they change together on
  // the edge that consumes a tick.
  assign h_sync      = (h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
  assign v_sync      = (v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
  assign de          = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
  assign x_pixel     = h_count;
  assign y_pixel     = v_count;
  assign line_start  = h_wrap;
  // The vertical axis only advances on a line wrap, so its wrap pulse is
  // exactly the frame wrap and always coincides with line_start.
  assign frame_start = v_wrap;

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_ctrl
// Drives a default 640x480 instance and a small, active-high-sync instance
// with identical stimulus. The reference model counts ticks since reset and
// derives every output arithmetically from that count.
// ---------------------------------------------------------------------------
module tb_vga_sync_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic pclk;

  logic       b_hs, b_vs, b_de, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  logic       s_hs, s_vs, s_de, s_ls, s_fs;
  logic [9:0] s_x, s_y;

  logic [24:0] big_vec, small_vec;
  assign big_vec   = {b_hs, b_vs, b_de, b_ls, b_fs, b_x, b_y};
  assign small_vec = {s_hs, s_vs, s_de, s_ls, s_fs, s_x, s_y};

  int checks = 0;
  int errors = 0;

  int          n = 0;
  bit          ticked = 1'b0;
  logic [24:0] exp_big, exp_small;
  int          sweep_bad = 0;
  int          first_bad_n;
  logic [24:0] first_act, first_exp;

  always #5 clk = ~clk;

  vga_sync_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .pclk        (pclk),
    .h_sync      (b_hs),
    .v_sync      (b_vs),
    .de          (b_de),
    .x_pixel     (b_x),
    .y_pixel     (b_y),
    .line_start  (b_ls),
    .frame_start (b_fs)
  );

  vga_sync_ctrl #(
    .H_VISIBLE (20), .H_FP (4), .H_SYNC (6), .H_BP (5),
    .V_VISIBLE (8),  .V_FP (2), .V_SYNC (2), .V_BP (3),
    .SYNC_POL  (1'b1)
  ) dut_small (
    .clk         (clk),
    .reset       (reset),
    .pclk        (pclk),
    .h_sync      (s_hs),
    .v_sync      (s_vs),
    .de          (s_de),
    .x_pixel     (s_x),
    .y_pixel     (s_y),
    .line_start  (s_ls),
    .frame_start (s_fs)
  );

  // Expected outputs after `ticks` ticks since reset.
  function automatic logic [24:0] model_vec(input int ticks, input bit tk,
                                            input int hv, input int hf, input int hs, input int hb,
                                            input int vv, input int vf, input int vs, input int vb,
                                            input bit pol);
    int ht, vt, x, y;
    logic h, v, d, ls, fs;
    logic [9:0] xs, ys;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    x  = ticks % ht;
    y  = (ticks / ht) % vt;
    h  = (x >= hv + hf && x < hv + hf + hs) ? pol : !pol;
    v  = (y >= vv + vf && y < vv + vf + vs) ? pol : !pol;
    d  = (x < hv) && (y < vv);
    ls = tk && (x == 0);
    fs = ls && (y == 0);
    xs = x[9:0];
    ys = y[9:0];
    return {h, v, d, ls, fs, xs, ys};
  endfunction

  // One clk: drive inputs on the falling edge, advance the model on the
  // rising edge, then sample both DUTs 1 ns later.
  task automatic cycle(input bit p, input bit r);
    @(negedge clk);
    pclk  = p;
    reset = r;
    @(posedge clk);
    if (!r) begin
      n = 0;
      ticked = 1'b0;
    end else if (p) begin
      n++;
      ticked = 1'b1;
    end else begin
      ticked = 1'b0;
    end
    #1;
    exp_big   = model_vec(n, ticked, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    exp_small = model_vec(n, ticked, 20, 4, 6, 5, 8, 2, 2, 3, 1'b1);
    if (big_vec !== exp_big || small_vec !== exp_small) begin
      if (sweep_bad == 0) begin
        first_bad_n = n;
        first_act   = (big_vec !== exp_big) ? big_vec : small_vec;
        first_exp   = (big_vec !== exp_big) ? exp_big : exp_small;
      end
      sweep_bad++;
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 8; c++) cycle((c % 4) == 3, 1'b0);
    checks++;
    if (big_vec !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0}) begin
      errors++;
      $display("[TB] FAIL reset_default: got %h want %h", big_vec,
               {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0});
    end
    checks++;
    if (small_vec !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0}) begin
      errors++;
      $display("[TB] FAIL reset_small: got %h want %h", small_vec,
               {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0});
    end
    checks++;
    if (sweep_bad !== 0) begin
      errors++;
      $display("[TB] FAIL reset_sweep: %0d clks off model, first at tick %0d got %h want %h",
               sweep_bad, first_bad_n, first_act, first_exp);
    end
    sweep_bad = 0;
  endtask

  task automatic test_h_phases();
    int clk_count = 0;
    int ls_seen   = 0;
    while (n < 800 && clk_count < 4000) begin
      cycle((clk_count % 4) == 3, 1'b1);
      clk_count++;
      if (b_ls) ls_seen++;
      if (ticked) begin
        case (n)
          639: begin
            checks++;
            if (b_x !== 10'd639 || b_de !== 1'b1) begin
              errors++;
              $display("[TB] FAIL tick639: x=%0d de=%b want x=639 de=1", b_x, b_de);
            end
          end
          640: begin
            checks++;
            if (b_x !== 10'd640 || b_de !== 1'b0) begin
              errors++;
              $display("[TB] FAIL tick640: x=%0d de=%b want x=640 de=0", b_x, b_de);
            end
          end
          655, 656, 751, 752: begin
            checks++;
            if (b_hs !== ((n == 656 || n == 751) ? 1'b0 : 1'b1)) begin
              errors++;
              $display("[TB] FAIL hsync_edge: at x=%0d h_sync=%b want %b", b_x, b_hs,
                       (n == 656 || n == 751) ? 1'b0 : 1'b1);
            end
          end
          800: begin
            checks++;
            if (b_x !== 10'd0 || b_y !== 10'd1 || b_ls !== 1'b1 || b_fs !== 1'b0) begin
              errors++;
              $display("[TB] FAIL line_wrap: x=%0d y=%0d ls=%b fs=%b want x=0 y=1 ls=1 fs=0",
                       b_x, b_y, b_ls, b_fs);
            end
          end
          default: ;
        endcase
      end
    end
    checks++;
    if (clk_count !== 3200) begin
      errors++;
      $display("[TB] FAIL line_clks: elapsed %0d clks want 3200", clk_count);
    end
    for (int c = 0; c < 3; c++) begin
      cycle(1'b0, 1'b1);
      if (b_ls) ls_seen++;
    end
    checks++;
    if (ls_seen !== 1) begin
      errors++;
      $display("[TB] FAIL line_start_width: high for %0d clks want 1", ls_seen);
    end
    checks++;
    if (sweep_bad !== 0) begin
      errors++;
      $display("[TB] FAIL h_phases_sweep: %0d clks off model, first at tick %0d got %h want %h",
               sweep_bad, first_bad_n, first_act, first_exp);
    end
    sweep_bad = 0;
  endtask

  // pclk held high: one pixel per clk, 15 more default lines.
  task automatic test_continuous();
    int ls_count = 0;
    for (int c = 0; c < 12000; c++) begin
      cycle(1'b1, 1'b1);
      if (b_ls) ls_count++;
    end
    checks++;
    if (ls_count !== 15) begin
      errors++;
      $display("[TB] FAIL continuous_lines: %0d line_start pulses want 15", ls_count);
    end
    checks++;
    if (sweep_bad !== 0) begin
      errors++;
      $display("[TB] FAIL continuous_sweep: %0d clks off model, first at tick %0d got %h want %h",
               sweep_bad, first_bad_n, first_act, first_exp);
    end
    sweep_bad = 0;
  endtask

  // Two complete frames of the small instance (35 x 15 = 525 ticks each).
  task automatic test_small_frames();
    int fs_count = 0;
    int vs_count = 0;
    int lone_fs  = 0;
    cycle(1'b0, 1'b0);
    for (int c = 0; c < 1050; c++) begin
      cycle(1'b1, 1'b1);
      if (s_fs) fs_count++;
      if (s_vs) vs_count++;
      if (s_fs && !s_ls) lone_fs++;
    end
    checks++;
    if (fs_count !== 2) begin
      errors++;
      $display("[TB] FAIL frame_pulses: %0d frame_start pulses want 2", fs_count);
    end
    checks++;
    if (vs_count !== 140) begin
      errors++;
      $display("[TB] FAIL vsync_width: v_sync asserted %0d clks want 140", vs_count);
    end
    checks++;
    if (lone_fs !== 0) begin
      errors++;
      $display("[TB] FAIL frame_with_line: %0d frame_start without line_start want 0", lone_fs);
    end
    checks++;
    if (s_x !== 10'd0 || s_y !== 10'd0 || s_fs !== 1'b1) begin
      errors++;
      $display("[TB] FAIL frame_wrap: x=%0d y=%0d fs=%b want 0 0 1", s_x, s_y, s_fs);
    end
    checks++;
    if (sweep_bad !== 0) begin
      errors++;
      $display("[TB] FAIL small_frames_sweep: %0d clks off model, first at tick %0d got %h want %h",
               sweep_bad, first_bad_n, first_act, first_exp);
    end
    sweep_bad = 0;
  endtask

  // Random tick gaps and occasional resets.
  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      cycle($urandom_range(2) == 0, $urandom_range(199) != 0);
    end
    checks++;
    if (sweep_bad !== 0) begin
      errors++;
      $display("[TB] FAIL random_sweep: %0d clks off model, first at tick %0d got %h want %h",
               sweep_bad, first_bad_n, first_act, first_exp);
    end
    sweep_bad = 0;
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    cycle(1'b0, 1'b0);
    while (n < 1100 && guard < 2000) begin
      cycle(1'b1, 1'b1);
      guard++;
    end
    checks++;
    if (b_x !== 10'd300 || b_y !== 10'd1) begin
      errors++;
      $display("[TB] FAIL mid_position: x=%0d y=%0d want 300 1", b_x, b_y);
    end
    cycle(1'b1, 1'b0);
    checks++;
    if (b_x !== 10'd0 || b_y !== 10'd0 || b_ls !== 1'b0 || b_fs !== 1'b0 || b_de !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_priority: x=%0d y=%0d ls=%b fs=%b de=%b want 0 0 0 0 1",
               b_x, b_y, b_ls, b_fs, b_de);
    end
    cycle(1'b1, 1'b1);
    checks++;
    if (b_x !== 10'd1 || b_y !== 10'd0) begin
      errors++;
      $display("[TB] FAIL after_reset_tick: x=%0d y=%0d want 1 0", b_x, b_y);
    end
    checks++;
    if (sweep_bad !== 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_sweep: %0d clks off model, first at tick %0d got %h want %h",
               sweep_bad, first_bad_n, first_act, first_exp);
    end
    sweep_bad = 0;
  endtask

  task automatic test_pclk_hold();
    int moved = 0;
    cycle(1'b0, 1'b0);
    for (int c = 0; c < 100; c++) cycle(1'b1, 1'b1);
    for (int c = 0; c < 1000; c++) begin
      cycle(1'b0, 1'b1);
      if (big_vec !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd100, 10'd0}) moved++;
    end
    checks++;
    if (moved !== 0) begin
      errors++;
      $display("[TB] FAIL hold_frozen: outputs changed on %0d of 1000 idle clks want 0", moved);
    end
    cycle(1'b1, 1'b1);
    checks++;
    if (b_x !== 10'd101 || b_ls !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_resume: x=%0d ls=%b want x=101 ls=0", b_x, b_ls);
    end
    checks++;
    if (sweep_bad !== 0) begin
      errors++;
      $display("[TB] FAIL pclk_hold_sweep: %0d clks off model, first at tick %0d got %h want %h",
               sweep_bad, first_bad_n, first_act, first_exp);
    end
    sweep_bad = 0;
  endtask

  initial begin
    reset = 1'b0;
    pclk  = 1'b0;
    test_reset();
    test_h_phases();
    test_continuous();
    test_small_frames();
    test_random();
    test_reset_mid();
    test_pclk_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
